// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter and the register file.
package rf_arb_pkg;
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } arb_state_t;

    localparam int RF_AW         = 5;
    localparam int RF_DW         = 32;
    localparam int RF_NREG       = 32;
    localparam int RF_R0         = 0;
    localparam int RF_STARVE_MAX = 8;
endpackage

// File: rtl/rf_arb_hold.sv
// One-entry holding buffer for long-latency results: handshake, WAW discard and starvation timer.
module rf_arb_hold
    import rf_arb_pkg::*;
#(
    parameter int AW         = RF_AW,
    parameter int DW         = RF_DW,
    parameter int STARVE_MAX = RF_STARVE_MAX
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          run,
    input  logic          pipe_req,
    input  logic [AW-1:0] pipe_waddr,
    input  logic          lu_valid,
    input  logic [AW-1:0] lu_waddr,
    input  logic [DW-1:0] lu_wdata,
    output logic          lu_ready,
    output logic          hold_v,
    output logic [AW-1:0] hold_addr,
    output logic [DW-1:0] hold_data,
    output logic          stall_req
);
    logic [7:0] wait_cnt;
    logic       drain;
    logic       waw_hit;
    logic       accept;

    assign lu_ready  = run & ~hold_v;
    assign drain     = hold_v & ~pipe_req;
    // a newer pipeline write to the same register supersedes the buffered one
    assign waw_hit   = hold_v & pipe_req & (pipe_waddr == hold_addr);
    assign accept    = lu_valid & lu_ready & (lu_waddr != AW'(RF_R0));
    assign stall_req = hold_v & (wait_cnt == 8'(STARVE_MAX));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_v    <= 1'b0;
            hold_addr <= '0;
            hold_data <= '0;
            wait_cnt  <= '0;
        end else begin
            if (drain || waw_hit) begin
                hold_v <= 1'b0;
            end else if (accept) begin
                hold_v    <= 1'b1;
                hold_addr <= lu_waddr;
                hold_data <= lu_wdata;
            end

            if (!hold_v || drain || waw_hit) begin
                wait_cnt <= '0;
            end else if (wait_cnt != 8'(STARVE_MAX)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port owner: post-reset clear of r1..NREG-1, then pipeline/long-latency arbitration.
//   state | meaning
//   CLEAR | writing zero to r clr_cnt, pipeline held off via busy
//   RUN   | pipeline write-back first, buffered lu write when the pipe is idle
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int AW         = RF_AW,
    parameter int DW         = RF_DW,
    parameter int NREG       = RF_NREG,
    parameter bit CLR_EN     = 1'b1,
    parameter int STARVE_MAX = RF_STARVE_MAX
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          pipe_we,
    input  logic [AW-1:0] pipe_waddr,
    input  logic [DW-1:0] pipe_wdata,
    input  logic          lu_valid,
    output logic          lu_ready,
    input  logic [AW-1:0] lu_waddr,
    input  logic [DW-1:0] lu_wdata,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          busy,
    output logic          pend_v,
    output logic [AW-1:0] pend_addr,
    output logic [DW-1:0] pend_data,
    output logic          stall_req
);
    arb_state_t    state;
    logic [AW-1:0] clr_cnt;
    logic          run;
    logic          pipe_req;
    logic          hold_v;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;

    assign run       = (state == RUN);
    assign busy      = (state == CLEAR);
    assign pipe_req  = run & pipe_we & (pipe_waddr != AW'(RF_R0));
    assign pend_v    = hold_v;
    assign pend_addr = hold_addr;
    assign pend_data = hold_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= CLR_EN ? CLEAR : RUN;
            clr_cnt <= AW'(1);
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + AW'(1);
            if (clr_cnt == AW'(NREG - 1)) begin
                state <= RUN;
            end
        end
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (state == CLEAR) begin
            rf_we    = 1'b1;
            rf_waddr = clr_cnt;
        end else if (pipe_req) begin
            rf_we    = 1'b1;
            rf_waddr = pipe_waddr;
            rf_wdata = pipe_wdata;
        end else if (hold_v) begin
            rf_we    = 1'b1;
            rf_waddr = hold_addr;
            rf_wdata = hold_data;
        end
    end

    rf_arb_hold #(
        .AW         (AW),
        .DW         (DW),
        .STARVE_MAX (STARVE_MAX)
    ) u_hold (
        .clk        (clk),
        .rstn       (rstn),
        .run        (run),
        .pipe_req   (pipe_req),
        .pipe_waddr (pipe_waddr),
        .lu_valid   (lu_valid),
        .lu_waddr   (lu_waddr),
        .lu_wdata   (lu_wdata),
        .lu_ready   (lu_ready),
        .hold_v     (hold_v),
        .hold_addr  (hold_addr),
        .hold_data  (hold_data),
        .stall_req  (stall_req)
    );

    // the pipeline must respect busy; the lu must respect lu_ready
    a_no_req_in_clear: assert property (@(posedge clk) disable iff (!rstn)
        (state == CLEAR) |-> !(pipe_we || lu_valid));
    a_lu_stable: assert property (@(posedge clk) disable iff (!rstn)
        (lu_valid && !lu_ready) |=> (lu_valid && $stable(lu_waddr) && $stable(lu_wdata)));
    a_no_r0_write: assert property (@(posedge clk) disable iff (!rstn)
        (state == RUN && rf_we) |-> (rf_waddr != AW'(RF_R0)));
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: expected rf writes are queued by the stimulus and popped by a monitor.
module tb_rf_write_arbiter;
    logic        clk;
    logic        rstn;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;
    logic        pend_v;
    logic [4:0]  pend_addr;
    logic [31:0] pend_data;
    logic        stall_req;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    rf_write_arbiter dut (
        .clk        (clk),
        .rstn       (rstn),
        .pipe_we    (pipe_we),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_waddr   (lu_waddr),
        .lu_wdata   (lu_wdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy       (busy),
        .pend_v     (pend_v),
        .pend_addr  (pend_addr),
        .pend_data  (pend_data),
        .stall_req  (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_clear();
        for (int r = 1; r < 32; r++) push(5'(r), 32'h0);
    endtask

    // monitor: every rf write while out of reset must match the head of the queue
    always @(negedge clk) begin
        exp_t e;
        if (rstn === 1'b1 && rf_we === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL rf_write: unexpected write r%0d=%h", rf_waddr, rf_wdata);
            end else begin
                e = q.pop_front();
                if (rf_waddr !== e.a || rf_wdata !== e.d) begin
                    bad++;
                    $display("FAIL rf_write: got r%0d=%h want r%0d=%h", rf_waddr, rf_wdata, e.a, e.d);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn       = 1'b0;
        pipe_we    = 1'b0;
        pipe_waddr = '0;
        pipe_wdata = '0;
        lu_valid   = 1'b0;
        lu_waddr   = '0;
        lu_wdata   = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_rf_we", rf_we, 1);
        chk("rst_rf_waddr", rf_waddr, 1);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_lu_ready", lu_ready, 0);
        chk("rst_pend_v", pend_v, 0);
        chk("rst_stall_req", stall_req, 0);

        tick();
        push_clear();
        rstn = 1'b1;
        repeat (31) @(negedge clk);
        chk("clear_busy_last", busy, 1);
        @(negedge clk);
        chk("clear_busy_fall", busy, 0);
        chk("clear_rf_we_off", rf_we, 0);
        chk("clear_lu_ready", lu_ready, 1);

        // pipeline write-back, same-cycle pass-through
        tick();
        pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'h1234;
        push(5'd5, 32'h1234);
        @(negedge clk);
        chk("pipe_rf_we", rf_we, 1);
        tick();
        pipe_waddr = 5'd0; pipe_wdata = 32'hDEAD;
        @(negedge clk);
        chk("pipe_r0_no_we", rf_we, 0);

        // lu write with pipe idle
        tick();
        pipe_we = 1'b0;
        lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'hBEEF;
        @(negedge clk);
        chk("lu_ready_before", lu_ready, 1);
        tick();
        lu_valid = 1'b0;
        push(5'd9, 32'hBEEF);
        @(negedge clk);
        chk("lu_pend_v", pend_v, 1);
        chk("lu_pend_addr", pend_addr, 9);
        chk("lu_pend_data", pend_data, 32'hBEEF);
        chk("lu_ready_busy", lu_ready, 0);
        tick();
        @(negedge clk);
        chk("lu_pend_v_drained", pend_v, 0);
        chk("lu_ready_after", lu_ready, 1);
        chk("lu_rf_we_idle", rf_we, 0);

        // lu write to r0 is accepted and dropped
        tick();
        lu_valid = 1'b1; lu_waddr = 5'd0; lu_wdata = 32'h5555;
        tick();
        lu_valid = 1'b0;
        @(negedge clk);
        chk("lu_r0_pend_v", pend_v, 0);
        chk("lu_r0_ready", lu_ready, 1);

        // starvation: pipe keeps priority for 8 cycles
        tick();
        lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'hBEEF;
        tick();
        lu_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h300 + 32'(k);
            push(5'd3, 32'h300 + 32'(k));
            @(negedge clk);
            chk("starve_stall_low", stall_req, 0);
            chk("starve_pend_v", pend_v, 1);
            tick();
        end
        pipe_we = 1'b0;
        push(5'd9, 32'hBEEF);
        @(negedge clk);
        chk("starve_stall_high", stall_req, 1);
        tick();
        @(negedge clk);
        chk("starve_stall_clear", stall_req, 0);
        chk("starve_pend_clear", pend_v, 0);

        // WAW: newer pipe write to the buffered register wins
        tick();
        lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'hBEEF;
        tick();
        lu_valid = 1'b0;
        pipe_we = 1'b1; pipe_waddr = 5'd9; pipe_wdata = 32'h1111;
        push(5'd9, 32'h1111);
        @(negedge clk);
        chk("waw_pend_v", pend_v, 1);
        tick();
        pipe_we = 1'b0;
        @(negedge clk);
        chk("waw_discard", pend_v, 0);
        chk("waw_no_write", rf_we, 0);

        // reset while a write is buffered
        tick();
        lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'hBEEF;
        tick();
        lu_valid = 1'b0;
        pipe_we = 1'b1; pipe_waddr = 5'd4; pipe_wdata = 32'h44;
        push(5'd4, 32'h44);
        @(negedge clk);
        chk("midrst_pend_before", pend_v, 1);
        #1;
        rstn = 1'b0;
        pipe_we = 1'b0;
        #1;
        chk("midrst_pend_v", pend_v, 0);
        chk("midrst_busy", busy, 1);
        chk("midrst_rf_waddr", rf_waddr, 1);
        tick();
        tick();
        push_clear();
        rstn = 1'b1;
        repeat (31) @(negedge clk);
        @(negedge clk);
        chk("midrst_busy_fall", busy, 0);
        chk("midrst_rf_we_off", rf_we, 0);
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the single write port of the 32x32 MIPS register file.
- After reset, it sequences a clear of r1..r31 to zero.
- It then shares the write port between the in-order pipeline write-back (highest priority, never stalled) and one long-latency unit (mul/div/load-miss) through a 1-entry holding buffer.
- It exposes the pending buffered write so hazard/forwarding logic can stall or forward.

Parameters:
- AW, 5, register address width
- DW, 32, data width
- NREG, 32, number of registers; clear covers 1..NREG-1
- CLR_EN, 1, 1 = run clear sequence after reset; 0 = go straight to RUN
- STARVE_MAX, 8, cycles a buffered write may wait before stall_req asserts (1..255)

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- pipe_we  in  1  pipeline write-back request
- pipe_waddr  in  AW  pipeline destination
- pipe_wdata  in  DW  pipeline data
- lu_valid  in  1  long-latency unit result valid
- lu_ready  out  1  arbiter can accept lu result
- lu_waddr  in  AW  lu destination
- lu_wdata  in  DW  lu data
- rf_we  out  1  register file write enable
- rf_waddr  out  AW  register file write address
- rf_wdata  out  DW  register file write data
- busy  out  1  clear sequence in progress; pipeline must hold off
- pend_v  out  1  buffered lu write pending
- pend_addr  out  AW  pending destination
- pend_data  out  DW  pending data (forwarding source)
- stall_req  out  1  request pipeline bubble to drain buffer

Behaviour:
- One clock domain, clk. rstn is asynchronous, active-low.
- State machine: states CLEAR and RUN.
- Reset values:
  - state=CLEAR (RUN if CLR_EN=0), clr_cnt=1, hold_v=0, wait_cnt=0.
  - Combinational outputs follow from these: busy=1, rf_we=1, rf_waddr=1, rf_wdata=0, lu_ready=0, pend_v=0, stall_req=0.
  - With CLR_EN=0, busy=0 and rf_we=0.
- CLEAR:
  - rf_we=1, rf_waddr=clr_cnt, rf_wdata=0; clr_cnt increments each cycle.
  - The cycle with clr_cnt==NREG-1 is the last clear write; state becomes RUN at the next edge.
  - Clear takes exactly NREG-1 (31) cycles after rstn deasserts.
  - pipe_we and lu_valid are ignored (protocol violation flagged by assertion); lu_ready=0.
- RUN, write-port mux (combinational, zero latency):
  - pipe_we=1 and pipe_waddr!=0: drive pipe fields; the buffer holds.
  - Otherwise, if hold_v=1: drive the hold fields; hold_v clears at the edge.
  - Otherwise rf_we=0.
  - rf_we is never asserted with rf_waddr=0 in RUN. A pipe write to r0 counts as no request.
- Handshake:
  - lu_ready = (state==RUN) & ~hold_v.
  - Transfer occurs on a clock edge with lu_valid & lu_ready. lu_waddr/lu_wdata are captured and hold_v sets.
  - lu_waddr=0 is accepted and discarded; hold_v stays 0.
  - lu must hold its fields stable while lu_valid=1 and lu_ready=0.
  - No accept in the same cycle the buffer drains; lu_ready rises the cycle after the drain.
- WAW rule:
  - If hold_v=1 and the pipeline writes pipe_waddr==hold addr, the pipe write is newer.
  - The hold entry is discarded (hold_v clears at that edge) and is never written.
- Starvation:
  - wait_cnt increments each cycle hold_v=1 and the buffer is not drained; it clears when hold_v=0.
  - It saturates at STARVE_MAX.
  - stall_req = hold_v & (wait_cnt==STARVE_MAX). It stays high until the buffer drains or is discarded.
  - The arbiter keeps pipeline priority even while stall_req=1.
- Pending outputs: pend_v=hold_v, pend_addr and pend_data = hold contents. Contents hold their last value when pend_v=0.
- Reset mid-operation: any rstn low returns to the reset values and drops the buffered write. Clear restarts from r1.

Decomposition:
- Shared package rf_arb_pkg contains:
  - state enum {CLEAR, RUN}
  - AW/DW defaults
  - R0 address constant
  - NREG constant, shared with reg_file
- One natural sub-module: rf_arb_hold. It contains the 1-entry buffer, the handshake, the WAW discard and wait_cnt/stall_req.
- The top level holds the state machine, clr_cnt and the write mux.

Test Plan:
- Release rstn, idle inputs -> rf_we=1 for 31 cycles with waddr 1..31 and wdata 0; busy falls on cycle 32; rf_we=0 afterwards.
- RUN, pipe_we=1, waddr=5, wdata=0x1234 -> rf_we=1, waddr=5, wdata=0x1234 in the same cycle; pipe waddr=0 -> rf_we=0.
- lu_valid with waddr=9, data=0xBEEF, pipe idle -> accept at edge N; cycle N+1: pend_v=1 and the rf writes r9=0xBEEF; cycle N+2: pend_v=0 and lu_ready=1.
- Hold r9 pending while the pipe writes r3 for 8 consecutive cycles -> stall_req=1 on the 9th pending cycle; first pipe-idle cycle writes r9; stall_req=0 on the next cycle.
- Hold r9=0xBEEF pending, pipe writes r9=0x1111 -> rf writes 0x1111 only; hold discarded; r9 is never written with 0xBEEF.
- Assert rstn low with hold_v=1 during RUN -> pend_v=0 immediately; after release, clear restarts at waddr=1 and the discarded write never appears.
